// File: rtl/decode_pkg.sv
// Shared constants for the ID stage: opcodes, ALU_Control codes, op_A_sel codes.
package decode_pkg;

    // RV32I major opcodes
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // ALU_Control: arithmetic ops are {2'b00, funct7[5], funct3},
    // branch compares are {3'b010, funct3}, jumps pass operand A through.
    localparam logic [5:0] ALU_ADD    = 6'b000000;
    localparam logic [2:0] ALU_BR_HI  = 3'b010;
    localparam logic [5:0] ALU_PASS_A = 6'b011111;

    // Operand A source
    localparam logic [1:0] OPA_RS1  = 2'b00;
    localparam logic [1:0] OPA_PC4  = 2'b01;
    localparam logic [1:0] OPA_PC   = 2'b10;
    localparam logic [1:0] OPA_ZERO = 2'b11;

    localparam logic [31:0] NOP = 32'h00000013;

endpackage

// File: rtl/decode_ctrl.sv
// Purely combinational RV32I field/control decode for one instruction word.
module decode_ctrl
    import decode_pkg::*;
(
    input  logic [31:0] instruction,
    output logic        wen,
    output logic        mem_wen,
    output logic        branch_op,
    output logic        op_b_sel,
    output logic        wb_sel,
    output logic [1:0]  op_a_sel,
    output logic [5:0]  alu_control,
    output logic [31:0] imm,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        illegal,
    output logic        uses_rs1,
    output logic        uses_rs2,
    output logic        is_jal
);

    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic        f7b5_s;
    logic        wen_raw_s;
    logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;

    assign opcode_s = instruction[6:0];
    assign funct3_s = instruction[14:12];
    assign f7b5_s   = instruction[30];
    assign rd       = instruction[11:7];

    assign imm_i_s = {{20{instruction[31]}}, instruction[31:20]};
    assign imm_s_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
    assign imm_b_s = {{19{instruction[31]}}, instruction[31], instruction[7],
                      instruction[30:25], instruction[11:8], 1'b0};
    assign imm_u_s = {instruction[31:12], 12'h000};
    assign imm_j_s = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                      instruction[20], instruction[30:21], 1'b0};

    // Writes to x0 never reach the register file.
    assign wen = wen_raw_s & (rd != 5'd0);

    // Source selects are zeroed when the format does not read that register.
    assign rs1 = uses_rs1 ? instruction[19:15] : 5'd0;
    assign rs2 = uses_rs2 ? instruction[24:20] : 5'd0;

    // Opcode-driven control decode; unknown opcodes fall through as a flagged NOP.
    always_comb begin
        wen_raw_s   = 1'b0;
        mem_wen     = 1'b0;
        branch_op   = 1'b0;
        op_b_sel    = 1'b0;
        wb_sel      = 1'b0;
        op_a_sel    = OPA_RS1;
        alu_control = ALU_ADD;
        imm         = 32'h00000000;
        illegal     = 1'b0;
        uses_rs1    = 1'b0;
        uses_rs2    = 1'b0;
        is_jal      = 1'b0;
        case (opcode_s)
            OP_R: begin
                wen_raw_s   = 1'b1;
                alu_control = {2'b00, f7b5_s, funct3_s};
                uses_rs1    = 1'b1;
                uses_rs2    = 1'b1;
            end
            OP_IMM: begin
                wen_raw_s = 1'b1;
                op_b_sel  = 1'b1;
                imm       = imm_i_s;
                uses_rs1  = 1'b1;
                // Only the shift-right pair carries an op bit in funct7.
                if (funct3_s == 3'b101) begin
                    alu_control = {2'b00, f7b5_s, funct3_s};
                end else begin
                    alu_control = {3'b000, funct3_s};
                end
            end
            OP_LOAD: begin
                wen_raw_s = 1'b1;
                wb_sel    = 1'b1;
                op_b_sel  = 1'b1;
                imm       = imm_i_s;
                uses_rs1  = 1'b1;
            end
            OP_STORE: begin
                mem_wen  = 1'b1;
                op_b_sel = 1'b1;
                imm      = imm_s_s;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_BRANCH: begin
                branch_op   = 1'b1;
                imm         = imm_b_s;
                alu_control = {ALU_BR_HI, funct3_s};
                uses_rs1    = 1'b1;
                uses_rs2    = 1'b1;
            end
            OP_JAL: begin
                wen_raw_s   = 1'b1;
                op_a_sel    = OPA_PC4;
                imm         = imm_j_s;
                alu_control = ALU_PASS_A;
                is_jal      = 1'b1;
            end
            OP_JALR: begin
                wen_raw_s   = 1'b1;
                op_a_sel    = OPA_PC4;
                op_b_sel    = 1'b1;
                imm         = imm_i_s;
                alu_control = ALU_PASS_A;
                uses_rs1    = 1'b1;
            end
            OP_LUI: begin
                wen_raw_s = 1'b1;
                op_a_sel  = OPA_ZERO;
                op_b_sel  = 1'b1;
                imm       = imm_u_s;
            end
            OP_AUIPC: begin
                wen_raw_s = 1'b1;
                op_a_sel  = OPA_PC;
                op_b_sel  = 1'b1;
                imm       = imm_u_s;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Pipelined decode: registered ID/EX slot with handshakes, load-use
// interlock, execute-driven flush and early JAL redirect.
module decode_stage
    import decode_pkg::*;
#(
    parameter int ADDRESS_BITS   = 16,
    parameter int LOAD_USE_STALL = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ADDRESS_BITS-1:0] in_PC,
    input  logic [31:0]             in_instruction,
    input  logic                    flush,
    output logic                    redirect_valid,
    output logic [ADDRESS_BITS-1:0] redirect_PC,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ADDRESS_BITS-1:0] out_PC,
    output logic [4:0]              read_sel1,
    output logic [4:0]              read_sel2,
    output logic [4:0]              write_sel,
    output logic                    wEn,
    output logic                    mem_wEn,
    output logic                    branch_op,
    output logic                    op_B_sel,
    output logic                    wb_sel,
    output logic [1:0]              op_A_sel,
    output logic [31:0]             imm32,
    output logic [5:0]              ALU_Control,
    output logic                    illegal
);

    logic        wen_s, mem_wen_s, branch_op_s, op_b_sel_s, wb_sel_s;
    logic [1:0]  op_a_sel_s;
    logic [5:0]  alu_control_s;
    logic [31:0] imm_s;
    logic [4:0]  rs1_s, rs2_s, rd_s;
    logic        illegal_s, uses_rs1_s, uses_rs2_s, is_jal_s;
    logic        hazard_s, accept_s, drain_s, slot_load_s;

    decode_ctrl u_ctrl (
        .instruction (in_instruction),
        .wen         (wen_s),
        .mem_wen     (mem_wen_s),
        .branch_op   (branch_op_s),
        .op_b_sel    (op_b_sel_s),
        .wb_sel      (wb_sel_s),
        .op_a_sel    (op_a_sel_s),
        .alu_control (alu_control_s),
        .imm         (imm_s),
        .rs1         (rs1_s),
        .rs2         (rs2_s),
        .rd          (rd_s),
        .illegal     (illegal_s),
        .uses_rs1    (uses_rs1_s),
        .uses_rs2    (uses_rs2_s),
        .is_jal      (is_jal_s)
    );

    assign slot_load_s = out_valid & wb_sel & wEn & (write_sel != 5'd0);

    // Load-use interlock: the incoming instruction reads the register the slot's load is still producing.
    always_comb begin
        hazard_s = 1'b0;
        if ((LOAD_USE_STALL != 0) && slot_load_s) begin
            hazard_s = (uses_rs1_s & (rs1_s == write_sel)) |
                       (uses_rs2_s & (rs2_s == write_sel));
        end else begin
            hazard_s = 1'b0;
        end
    end

    assign in_ready = reset & ~flush & ~redirect_valid & (~out_valid | out_ready) & ~hazard_s;
    assign accept_s = in_valid & in_ready;
    assign drain_s  = out_valid & out_ready;

    // ID/EX slot: reset, then flush, then accept, then drain; data fields only move on accept.
    always_ff @(posedge clock) begin
        if (!reset) begin
            out_valid   <= 1'b0;
            out_PC      <= '0;
            read_sel1   <= 5'd0;
            read_sel2   <= 5'd0;
            write_sel   <= 5'd0;
            wEn         <= 1'b0;
            mem_wEn     <= 1'b0;
            branch_op   <= 1'b0;
            op_B_sel    <= 1'b0;
            wb_sel      <= 1'b0;
            op_A_sel    <= 2'b00;
            imm32       <= 32'h00000000;
            ALU_Control <= 6'b000000;
            illegal     <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept_s) begin
            out_valid   <= 1'b1;
            out_PC      <= in_PC;
            read_sel1   <= rs1_s;
            read_sel2   <= rs2_s;
            write_sel   <= rd_s;
            wEn         <= wen_s;
            mem_wEn     <= mem_wen_s;
            branch_op   <= branch_op_s;
            op_B_sel    <= op_b_sel_s;
            wb_sel      <= wb_sel_s;
            op_A_sel    <= op_a_sel_s;
            imm32       <= imm_s;
            ALU_Control <= alu_control_s;
            illegal     <= illegal_s;
        end else if (drain_s) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= out_valid;
        end
    end

    // JAL redirect: one-cycle pulse carrying the jump target (PC arithmetic wraps).
    always_ff @(posedge clock) begin
        if (!reset) begin
            redirect_valid <= 1'b0;
            redirect_PC    <= '0;
        end else if (accept_s && is_jal_s) begin
            redirect_valid <= 1'b1;
            redirect_PC    <= in_PC + imm_s[ADDRESS_BITS-1:0];
        end else begin
            redirect_valid <= 1'b0;
        end
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Pipelined, parametrised successor to the single-cycle RV32I decoder. Sits between fetch and execute and decodes one instruction per cycle into a registered ID/EX slot with valid/ready handshakes on both sides. Adds what the single-cycle decoder lacks: a load-use interlock, an execute-driven flush, an early JAL redirect and illegal-opcode flagging. Control encodings are unchanged from the current decoder, so the execute/ALU, memory and writeback blocks connect without modification.

## Interface
- ADDRESS_BITS, 16, PC/target width.
- LOAD_USE_STALL, 1, enables the load-use interlock when 1; 0 disables it.
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  decode accepts this cycle.
- in_PC  in  ADDRESS_BITS  PC of in_instruction.
- in_instruction  in  32  RV32I instruction word.
- flush  in  1  execute resolved a taken branch/JALR; discard the ID/EX slot and the input.
- redirect_valid  out  1  one-cycle JAL redirect pulse to fetch.
- redirect_PC  out  ADDRESS_BITS  JAL target.
- out_valid  out  1  ID/EX slot holds a valid instruction.
- out_ready  in  1  execute consumes the slot.
- out_PC  out  ADDRESS_BITS  registered PC.
- read_sel1, read_sel2, write_sel  out  5 each  rs1, rs2, rd.
- wEn, mem_wEn, branch_op, op_B_sel, wb_sel  out  1 each  same meaning as the current decoder.
- op_A_sel  out  2  00 = rs1, 01 = PC+4, 10 = PC, 11 = zero.
- imm32  out  32  sign-extended immediate.
- ALU_Control  out  6  existing encoding.
- illegal  out  1  unknown opcode in the slot.

## Operation
- Combinational decode of in_instruction, then a single ID/EX register.
- Opcodes: R, I-ALU, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC.
- Unknown opcode: decodes as a NOP (wEn = mem_wEn = branch_op = 0) with illegal = 1.
- Writes to x0 are dropped: write_sel = 0 forces wEn = 0.
- Definitions used below:
  - accept = in_valid & in_ready.
  - drain = out_valid & out_ready.
  - in_ready = reset & !flush & !redirect_valid & (!out_valid | out_ready) & !hazard.
- hazard (LOAD_USE_STALL = 1 only) is asserted when all of these hold:
  - the slot holds a load (out_valid & wb_sel & wEn);
  - its write_sel ≠ 0;
  - write_sel matches an rs field actually used by the input instruction (rs1 for I/LOAD/STORE/BRANCH/JALR/R; rs2 for R/STORE/BRANCH).
- hazard blocks accept. If the load drains in the same cycle, the slot empties and exactly one bubble is inserted.
- Slot update priority (highest first):
  1. reset low: out_valid ← 0.
  2. flush: out_valid ← 0.
  3. accept: load the slot, out_valid ← 1.
  4. drain: out_valid ← 0.
  5. otherwise: hold.
- When the slot is not updated, all data outputs hold their values (stable while out_valid & !out_ready).
- JAL accepted: redirect_valid ← 1 and redirect_PC ← in_PC + imm32[ADDRESS_BITS-1:0] on the next cycle, for exactly one cycle.
  - During that cycle in_ready = 0; fetch squashes the wrong-path word.
  - The JAL itself proceeds with op_A_sel = 01 (link PC+4).
  - flush in the pulse cycle does not cancel the pulse.
- JALR and branches are resolved in execute: branch_op = 1 for BRANCH; imm32 and out_PC are passed through.
- All PC arithmetic is modulo 2^ADDRESS_BITS; carries out are discarded.

## Timing
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 instruction/cycle when out_ready is held high and there is no hazard.
- Reset state: all outputs 0, including out_valid, redirect_valid, illegal, imm32 and ALU_Control. in_ready = 0 while reset is low.
- flush takes effect at the next edge. It overrides a simultaneous accept and a simultaneous drain; the drained instruction is still consumed by execute that cycle.
- Reset low mid-stall or mid-redirect clears everything at the next edge.

## Structure
- Package decode_pkg holds:
  - opcode constants;
  - ALU_Control codes, shared with the ALU;
  - op_A_sel codes;
  - NOP = 32'h00000013.
- One combinational sub-module, decode_ctrl: instruction → control/immediate fields plus uses_rs1/uses_rs2.
- decode_stage adds the slot register, handshake, hazard and redirect logic on top of it.

## Test plan
- Reset, then `addi a1, zero, -1` with out_ready = 1 → next cycle: out_valid = 1, write_sel = 11, imm32 = 0xFFFFFFFF, op_B_sel = 1, wEn = 1.
- `lw s2, 0(a1)` followed by `add a6, s2, a2`, out_ready = 1 → in_ready = 0 for one cycle, one bubble (out_valid = 0), then add issues.
  - Repeat with LOAD_USE_STALL = 0 → no bubble.
- PC = 0x0114, instruction 0x0140006F (jal zero) → redirect_valid pulses one cycle with redirect_PC = 0x0128; in_ready = 0 in the pulse cycle.
- Slot valid, out_ready = 0 for 3 cycles → all outputs stable; in_ready = 0. Then flush with in_valid = 1 → out_valid = 0 next cycle, input not accepted.
- PC = 0xFFFC, JAL with imm = +8 → redirect_PC = 0x0004 (wrap-around).
- Opcode 7'b1111111 → illegal = 1, wEn = mem_wEn = 0. Also `add zero, a1, a2` → wEn = 0.
